// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (LSL/LSR/ASR, optional ROL/ROR) with a valid/ready handshake and a global stall.
// Define PIPELINED_SHIFTER_ROTATE_EN to build the rotate datapath; otherwise Op 011/100 are reported as illegal.
module pipelined_shifter #(
  parameter int nBITS  = 32,
  parameter int STAGES = 2
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [nBITS-1:0]         In,
  input  logic [$clog2(nBITS)-1:0] ShiftAmount,
  input  logic [2:0]               Op,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [nBITS-1:0]         Out,
  output logic                     CarryOut,
  output logic                     Zero,
  output logic                     IllegalOp
);
  localparam int AW   = $clog2(nBITS);
  localparam int LVLS = AW;
  localparam int LPS  = (LVLS + STAGES - 1) / STAGES;
  localparam logic [2:0] OP_LSL = 3'd0, OP_LSR = 3'd1, OP_ASR = 3'd2;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
  localparam logic [2:0] OP_ROL = 3'd3, OP_ROR = 3'd4;
  localparam logic [2:0] OP_MAX = 3'd4;
`else
  localparam logic [2:0] OP_MAX = 3'd2;
`endif
  localparam logic [nBITS-1:0] ONE  = nBITS'(1);
  localparam logic [AW-1:0]    AONE = AW'(1);

  typedef struct packed {
    logic [nBITS-1:0] data;
    logic [2:0]       op;
    logic [AW-1:0]    amt;
    logic             sign;
    logic             carry;
    logic             zero;
    logic             ill;
  } stage_t;

  // One binary level: shift by 2^k when amt bit k is set; carry tracks the last bit pushed out.
  function automatic stage_t do_level(input stage_t x, input int k);
    stage_t y;
    int     d;
    y = x;
    d = 1 << k;
    if ((|(x.amt & (AONE << k))) && !x.ill) begin
      case (x.op)
        OP_LSL: begin
          y.carry = |(x.data & (ONE << (nBITS - d)));
          y.data  = x.data << d;
        end
        OP_LSR: begin
          y.carry = |(x.data & (ONE << (d - 1)));
          y.data  = x.data >> d;
        end
        OP_ASR: begin
          y.carry = |(x.data & (ONE << (d - 1)));
          y.data  = (x.data >> d) | ({nBITS{x.sign}} << (nBITS - d));
        end
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        OP_ROL: begin
          y.data  = (x.data << d) | (x.data >> (nBITS - d));
          y.carry = y.data[0];
        end
        OP_ROR: begin
          y.data  = (x.data >> d) | (x.data << (nBITS - d));
          y.carry = y.data[nBITS-1];
        end
`endif
        default: ;
      endcase
    end
    return y;
  endfunction

  logic              advance;
  logic [STAGES:1]   vld_pipe_q;
  stage_t            head;
  stage_t            src   [STAGES];
  stage_t            nxt   [STAGES];
  stage_t            stg_q [STAGES];

  // Global stall: every stage holds together, so bubbles are never squeezed out.
  assign advance = !vld_pipe_q[STAGES] || OutReady;
  assign InReady = advance;

  always_comb begin
    head      = '0;
    head.data = In;
    head.op   = Op;
    head.amt  = ShiftAmount;
    head.sign = In[nBITS-1];
    head.ill  = (Op > OP_MAX);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_pipe_q <= '0;
    end else if (advance) begin
      vld_pipe_q[1] <= InValid;
      for (int s = 2; s <= STAGES; s++) vld_pipe_q[s] <= vld_pipe_q[s-1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * LPS;
    localparam int HI = ((s + 1) * LPS < LVLS) ? (s + 1) * LPS : LVLS;

    if (s == 0) begin : g_head
      assign src[s] = head;
    end else begin : g_mid
      assign src[s] = stg_q[s-1];
    end

    always_comb begin
      stage_t v;
      v = src[s];
      for (int k = LO; k < HI; k++) v = do_level(v, k);
      v.zero = (v.data == '0);
      nxt[s] = v;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n)     stg_q[s] <= '0;
      else if (advance) stg_q[s] <= nxt[s];
    end
  end

  assign OutValid  = vld_pipe_q[STAGES];
  assign Out       = stg_q[STAGES-1].data;
  assign CarryOut  = stg_q[STAGES-1].carry;
  assign Zero      = stg_q[STAGES-1].zero;
  assign IllegalOp = stg_q[STAGES-1].ill;
endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: directed vectors push expectations, a negedge monitor pops and checks.
module tb_pipelined_shifter;
  localparam int N  = 32;
  localparam int ST = 2;

  logic         Clock = 0;
  logic         Reset_n;
  logic         InValid;
  logic         InReady;
  logic [N-1:0] In;
  logic [4:0]   ShiftAmount;
  logic [2:0]   Op;
  logic         OutValid;
  logic         OutReady;
  logic [N-1:0] Out;
  logic         CarryOut, Zero, IllegalOp;

  pipelined_shifter #(.nBITS(N), .STAGES(ST)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
    .In(In), .ShiftAmount(ShiftAmount), .Op(Op), .OutValid(OutValid),
    .OutReady(OutReady), .Out(Out), .CarryOut(CarryOut), .Zero(Zero),
    .IllegalOp(IllegalOp)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [N-1:0] o;
    logic         c, z, i;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad   = 0;
  int           nxfer = 0;
  bit           prev_stall = 0;
  bit           saw_low = 0;
  logic [N-1:0] h_out;
  logic         h_c, h_z, h_i;

  // Monitor: checks each transfer against the scoreboard and holds steady during stalls.
  always @(negedge Clock) begin
    if (!Reset_n) begin
      prev_stall = 0;
    end else begin
      if (!InReady) saw_low = 1;
      if (prev_stall) begin
        total++;
        if (!OutValid || Out !== h_out || CarryOut !== h_c || Zero !== h_z || IllegalOp !== h_i) begin
          bad++;
          $display("FAIL stall_hold v=%b out=%h c=%b z=%b i=%b want v=1 out=%h c=%b z=%b i=%b",
                   OutValid, Out, CarryOut, Zero, IllegalOp, h_out, h_c, h_z, h_i);
        end
      end
      prev_stall = OutValid && !OutReady;
      h_out = Out; h_c = CarryOut; h_z = Zero; h_i = IllegalOp;
      if (OutValid && OutReady) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL xfer%0d unexpected out=%h", nxfer, Out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (Out !== e.o || CarryOut !== e.c || Zero !== e.z || IllegalOp !== e.i) begin
            bad++;
            $display("FAIL xfer%0d out=%h c=%b z=%b i=%b want out=%h c=%b z=%b i=%b",
                     nxfer, Out, CarryOut, Zero, IllegalOp, e.o, e.c, e.z, e.i);
          end
        end
        nxfer++;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [N-1:0] din, input logic [4:0] amt, input logic [2:0] op,
                      input logic [N-1:0] eo, input logic ec, input logic ei);
    bit r;
    int n;
    In = din; ShiftAmount = amt; Op = op; InValid = 1;
    sb.push_back('{eo, ec, (eo == '0), ei});
    r = 0; n = 0;
    while (!r && n < 100) begin
      @(negedge Clock); r = InReady;
      @(posedge Clock); #1; n++;
    end
    InValid = 0;
    if (!r) begin
      total++; bad++;
      void'(sb.pop_back());
      $display("FAIL send_timeout in=%h want accept within 100 cycles", din);
    end
  endtask

  initial begin
    int n;
    Reset_n = 0; InValid = 0; OutReady = 1; In = '0; ShiftAmount = '0; Op = '0;
    #2;
    check("reset_state", {59'd0, OutValid, CarryOut, Zero, IllegalOp, InReady},
          {59'd0, 5'b00001});
    check("reset_out", {32'd0, Out}, 64'd0);
    #10 Reset_n = 1;
    @(posedge Clock); #1;

    // Latency: valid must appear exactly two cycles after acceptance.
    send(32'h0000_0001, 5'd31, 3'd0, 32'h8000_0000, 1'b0, 1'b0);
    check("lat_early", {63'd0, OutValid}, 64'd0);
    @(posedge Clock); #1;
    check("lat_on_time", {63'd0, OutValid}, 64'd1);

    send(32'h8000_0000, 5'd4,  3'd2, 32'hF800_0000, 1'b0, 1'b0);
    send(32'h8000_0000, 5'd4,  3'd1, 32'h0800_0000, 1'b0, 1'b0);
    send(32'h0000_0018, 5'd4,  3'd1, 32'h0000_0001, 1'b1, 1'b0);
`ifdef PIPELINED_SHIFTER_ROTATE_EN
    send(32'h0000_0001, 5'd1,  3'd4, 32'h8000_0000, 1'b1, 1'b0);
    send(32'h8000_0000, 5'd4,  3'd3, 32'h0000_0008, 1'b0, 1'b0);
`else
    send(32'h0000_0001, 5'd1,  3'd4, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h8000_0000, 5'd4,  3'd3, 32'h8000_0000, 1'b0, 1'b1);
`endif
    send(32'h0000_0000, 5'd0,  3'd0, 32'h0000_0000, 1'b0, 1'b0);
    send(32'h1234_5678, 5'd5,  3'd7, 32'h1234_5678, 1'b0, 1'b1);
    send(32'h1234_5678, 5'd9,  3'd5, 32'h1234_5678, 1'b0, 1'b1);
    send(32'h8000_0001, 5'd1,  3'd0, 32'h0000_0002, 1'b1, 1'b0);
    send(32'h8000_000F, 5'd1,  3'd2, 32'hC000_0007, 1'b1, 1'b0);
    send(32'hFFFF_FFFF, 5'd31, 3'd1, 32'h0000_0001, 1'b1, 1'b0);
    send(32'hFFFF_FFFF, 5'd0,  3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'h8000_0000, 5'd31, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 5'd0,  3'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (4) @(posedge Clock); #1;

    // Backpressure: output held for 5 cycles while 4 requests are pushed.
    saw_low = 0;
    OutReady = 0;
    fork
      begin
        send(32'h0000_0003, 5'd1, 3'd0, 32'h0000_0006, 1'b0, 1'b0);
        send(32'h0000_0100, 5'd8, 3'd1, 32'h0000_0001, 1'b0, 1'b0);
        send(32'hF000_0000, 5'd4, 3'd0, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h0000_00F0, 5'd4, 3'd2, 32'h0000_000F, 1'b0, 1'b0);
      end
      begin
        repeat (5) @(posedge Clock); #1;
        OutReady = 1;
      end
    join
    check("stall_inready_low", {63'd0, saw_low}, 64'd1);
    repeat (4) @(posedge Clock); #1;

    // Reset with two requests in flight: both must vanish.
    OutReady = 0;
    send(32'h0000_0001, 5'd1, 3'd0, 32'h0000_0002, 1'b0, 1'b0);
    send(32'h0000_0002, 5'd1, 3'd0, 32'h0000_0004, 1'b0, 1'b0);
    #2 Reset_n = 0;
    #1;
    check("rst_flush", {30'd0, OutValid, InReady, Out}, {30'd0, 2'b01, 32'd0});
    sb.delete();
    @(posedge Clock); #3;
    Reset_n = 1; OutReady = 1;
    @(posedge Clock); #1;
    check("rst_no_ghost", {63'd0, OutValid}, 64'd0);
    send(32'h0000_00A5, 5'd4, 3'd0, 32'h0000_0A50, 1'b0, 1'b0);
    check("post_rst_early", {63'd0, OutValid}, 64'd0);
    @(posedge Clock); #1;
    check("post_rst_valid", {63'd0, OutValid}, 64'd1);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge Clock); #1; n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge Clock); #1;
    check("idle_valid", {63'd0, OutValid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
